// File: rtl/ahb_core_ctrl_pkg.sv
// Shared encodings for the AHB core sleep controller: bus codes, register
// offsets and the bus-side state type.
package ahb_core_ctrl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [1:0] HSIZE_WORD = 2'b10;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_DELAY  = 8'h08;
    localparam logic [7:0] OFF_DONE   = 8'h0C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR1   = 2'd2,
        ST_ERR2   = 2'd3
    } bus_state_e;

    // CTRL is write-only and STATUS read-only; only full-word accesses are legal.
    function automatic logic access_ok(input logic [7:0] off, input logic wr,
                                       input logic [1:0] size);
        logic ok;
        case (off)
            OFF_CTRL:   ok = wr;
            OFF_STATUS: ok = !wr;
            OFF_DELAY:  ok = 1'b1;
            OFF_DONE:   ok = 1'b1;
            default:    ok = 1'b0;
        endcase
        return ok && (size == HSIZE_WORD);
    endfunction

endpackage

// File: rtl/ahb_core_ctrl_timer.sv
// Per-core sleep hold and finish-to-sleep down-delay: tracks go, a saturating
// count, the registered sleep line and a one-cycle done-set pulse.
module core_sleep_timer #(
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               finish_i,
    input  logic               wake_i,
    input  logic               force_sleep_i,
    input  logic [DELAY_W-1:0] delay_i,
    output logic               sleep_o,
    output logic               go_o,
    output logic               done_set_o
);

    logic               sleep_q, sleep_d;
    logic               go_q, go_d;
    logic [DELAY_W-1:0] count_q, count_d;
    logic               expire;

    // Priority: force-sleep, then expiry, then wake; expiry beats a same-edge wake.
    always_comb begin
        expire  = go_q && (count_q >= delay_i);
        sleep_d = sleep_q;
        go_d    = go_q;
        count_d = count_q;
        if (force_sleep_i) begin
            sleep_d = 1'b1;
            go_d    = 1'b0;
            count_d = '0;
        end else if (expire) begin
            sleep_d = 1'b1;
            go_d    = 1'b0;
            count_d = '0;
        end else begin
            if (wake_i) begin
                sleep_d = 1'b0;
            end
            if (go_q) begin
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
            end else if (finish_i && !sleep_q) begin
                go_d    = 1'b1;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sleep_q <= 1'b1;
            go_q    <= 1'b0;
            count_q <= '0;
        end else begin
            sleep_q <= sleep_d;
            go_q    <= go_d;
            count_q <= count_d;
        end
    end

    assign sleep_o    = sleep_q;
    assign go_o       = go_q;
    assign done_set_o = expire && !force_sleep_i;

endmodule

// File: rtl/ahb_core_ctrl.sv
// AHB-lite slave that holds cores in sleep, wakes them on CTRL writes and
// returns each to sleep a programmable delay after its finish pulse.
//   state  | meaning
//   IDLE   | no data phase in progress
//   ACCESS | zero-wait data phase of a legal transfer
//   ERR1   | first error cycle, HREADYOut low
//   ERR2   | second error cycle, HREADYOut high
module ahb_core_ctrl
    import ahb_core_ctrl_pkg::*;
#(
    parameter int N_CORES   = 4,
    parameter int DELAY_W   = 8,
    parameter int DELAY_RST = 128
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSEL,
    input  logic               HREADYIn,
    input  logic               HWRITE,
    input  logic [1:0]         HTRANS,
    input  logic [1:0]         HSIZE,
    input  logic [31:0]        HADDR,
    input  logic [31:0]        HWDATA,
    output logic               HREADYOut,
    output logic [1:0]         HRESP,
    output logic [31:0]        HRDATA,
    input  logic [N_CORES-1:0] program_finish_i,
    output logic [N_CORES-1:0] sleep_o,
    output logic               irq_o
);

    bus_state_e         state_q, state_d;
    logic [7:0]         addr_q, addr_d;
    logic               write_q, write_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [N_CORES-1:0] done_q, done_d;
    logic               irq_q, irq_d;

    logic               valid;
    logic               wr_ctrl, wr_delay, wr_done;
    logic [N_CORES-1:0] wake, force_sleep, go, done_set;
    logic [31:0]        status_word;
    logic               unused_ok;

    assign valid = HSEL && HREADYIn &&
                   ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            delay_q <= DELAY_W'(DELAY_RST);
            done_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            delay_q <= delay_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
        end
    end

    // New address phases are only accepted while HREADYOut is high outside an error.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        case (state_q)
            ST_IDLE, ST_ACCESS: begin
                state_d = ST_IDLE;
                if (valid) begin
                    addr_d  = HADDR[7:0];
                    write_d = HWRITE;
                    state_d = access_ok(HADDR[7:0], HWRITE, HSIZE) ? ST_ACCESS : ST_ERR1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        status_word = '0;
        status_word[16 +: N_CORES] = go;
        status_word[0 +: N_CORES]  = sleep_o;
    end

    always_comb begin
        HREADYOut = (state_q != ST_ERR1);
        HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA    = '0;
        wr_ctrl   = 1'b0;
        wr_delay  = 1'b0;
        wr_done   = 1'b0;
        if (state_q == ST_ACCESS) begin
            if (write_q) begin
                case (addr_q)
                    OFF_CTRL:  wr_ctrl  = 1'b1;
                    OFF_DELAY: wr_delay = 1'b1;
                    OFF_DONE:  wr_done  = 1'b1;
                    default:   ;
                endcase
            end else begin
                case (addr_q)
                    OFF_STATUS: HRDATA = status_word;
                    OFF_DELAY:  HRDATA[DELAY_W-1:0] = delay_q;
                    OFF_DONE:   HRDATA[N_CORES-1:0] = done_q;
                    default:    ;
                endcase
            end
        end
    end

    // A same-edge set beats the write-1-clear.
    always_comb begin
        wake        = wr_ctrl ? HWDATA[N_CORES-1:0] : '0;
        force_sleep = wr_ctrl ? HWDATA[16 +: N_CORES] : '0;
        delay_d     = wr_delay ? HWDATA[DELAY_W-1:0] : delay_q;
        done_d      = (done_q & ~(wr_done ? HWDATA[N_CORES-1:0] : '0)) | done_set;
        irq_d       = |done_q;
    end

    for (genvar i = 0; i < N_CORES; i++) begin : g_core
        core_sleep_timer #(.DELAY_W(DELAY_W)) u_timer (
            .clk          (HCLK),
            .rst_n        (HRESETn),
            .finish_i     (program_finish_i[i]),
            .wake_i       (wake[i]),
            .force_sleep_i(force_sleep[i]),
            .delay_i      (delay_q),
            .sleep_o      (sleep_o[i]),
            .go_o         (go[i]),
            .done_set_o   (done_set[i])
        );
    end

    assign irq_o     = irq_q;
    assign unused_ok = &{1'b0, HADDR[31:8], HWDATA};

endmodule

// File: tb/tb_ahb_core_ctrl.sv
// Directed bench for ahb_core_ctrl: bus reads/writes, finish-to-sleep timing,
// error responses and same-edge priority cases, all against hand-computed values.
module tb_ahb_core_ctrl;
    import ahb_core_ctrl_pkg::*;

    localparam int N = 4;

    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic        HSEL = 1'b0, HREADYIn = 1'b1, HWRITE = 1'b0;
    logic [1:0]  HTRANS = HTRANS_IDLE, HSIZE = HSIZE_WORD;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic        HREADYOut;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic [N-1:0] finish = '0, sleep;
    logic        irq;

    int errors = 0, checks = 0, cyc = 0, t0 = 0;
    int rise_cyc [N];
    logic [N-1:0] sleep_prev = '1;
    logic [31:0] rd;

    ahb_core_ctrl #(.N_CORES(N), .DELAY_W(8), .DELAY_RST(128)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADYIn(HREADYIn),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR),
        .HWDATA(HWDATA), .HREADYOut(HREADYOut), .HRESP(HRESP), .HRDATA(HRDATA),
        .program_finish_i(finish), .sleep_o(sleep), .irq_o(irq)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc++;

    // Record the edge index at which each sleep line rises.
    always @(posedge HCLK) begin
        #1;
        for (int i = 0; i < N; i++)
            if (sleep[i] && !sleep_prev[i]) rise_cyc[i] = cyc;
        sleep_prev = sleep;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic ahb_wr(input logic [7:0] off, input logic [31:0] data);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        HADDR = {24'h0, off};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = data;
        @(negedge HCLK);
    endtask

    task automatic ahb_rd(input logic [7:0] off, output logic [31:0] data);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
        HADDR = {24'h0, off};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        data = HRDATA;
    endtask

    task automatic ahb_err(input string tag, input logic [7:0] off, input logic wr,
                           input logic [1:0] size);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HSIZE = size;
        HADDR = {24'h0, off};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
        HWDATA = 32'hFFFF_FFFF;
        chk({tag, "_c1"}, {29'h0, HREADYOut, HRESP}, {29'h0, 1'b0, HRESP_ERROR});
        @(negedge HCLK);
        chk({tag, "_c2"}, {29'h0, HREADYOut, HRESP}, {29'h0, 1'b1, HRESP_ERROR});
        @(negedge HCLK);
        chk({tag, "_c3"}, {29'h0, HREADYOut, HRESP}, {29'h0, 1'b1, HRESP_OKAY});
    endtask

    task automatic pulse(input int c, output int t);
        rise_cyc[c] = -1;
        @(negedge HCLK);
        finish[c] = 1'b1;
        @(negedge HCLK);
        finish = '0;
        t = cyc;
    endtask

    task automatic wait_rise(input int c);
        for (int k = 0; k < 300 && rise_cyc[c] < 0; k++) @(negedge HCLK);
    endtask

    initial begin
        for (int i = 0; i < N; i++) rise_cyc[i] = -1;

        // Reset values
        repeat (3) @(negedge HCLK);
        chk("rst_sleep", sleep, 32'hF);
        chk("rst_irq", irq, 0);
        chk("rst_bus", {HREADYOut, HRESP}, {1'b1, HRESP_OKAY});
        chk("rst_hrdata", HRDATA, 0);
        HRESETn = 1'b1;
        ahb_rd(OFF_STATUS, rd); chk("status_rst", rd, 32'h0000_000F);
        ahb_rd(OFF_DELAY, rd);  chk("delay_rst", rd, 32'h80);
        ahb_rd(OFF_DONE, rd);   chk("done_rst", rd, 0);

        // Wake core 0, finish, default delay of 128
        ahb_wr(OFF_CTRL, 32'h1);
        chk("wake0", sleep, 32'hE);
        pulse(0, t0);
        ahb_rd(OFF_STATUS, rd); chk("status_go0", rd, 32'h0001_000E);
        wait_rise(0);
        chk("rise0_d128", rise_cyc[0] - t0, 129);
        chk("irq_lag", irq, 0);
        @(negedge HCLK);
        chk("irq_set", irq, 1);
        ahb_rd(OFF_DONE, rd); chk("done0", rd, 32'h1);
        ahb_wr(OFF_DONE, 32'h1);
        chk("irq_hold", irq, 1);
        @(negedge HCLK);
        chk("irq_clr", irq, 0);
        ahb_rd(OFF_DONE, rd); chk("done_w1c", rd, 0);

        // Wake and force-sleep together: sleep wins
        ahb_wr(OFF_CTRL, 32'h1);
        chk("wake0_b", sleep, 32'hE);
        ahb_wr(OFF_CTRL, 32'h0001_0001);
        chk("sleep_wins", sleep, 32'hF);

        // Finish while asleep is ignored
        pulse(1, t0);
        ahb_rd(OFF_STATUS, rd); chk("finish_asleep", rd, 32'h0000_000F);

        // Force-sleep during a count
        ahb_wr(OFF_DELAY, 32'h3);
        ahb_wr(OFF_CTRL, 32'h4);
        chk("wake2", sleep, 32'hB);
        pulse(2, t0);
        ahb_wr(OFF_CTRL, 32'h0004_0000);
        chk("force_rise2", rise_cyc[2] - t0, 3);
        repeat (6) @(negedge HCLK);
        ahb_rd(OFF_DONE, rd); chk("force_no_done", rd, 0);
        chk("force_no_irq", irq, 0);

        // Error responses
        ahb_err("err_unmapped", 8'h10, 1'b0, HSIZE_WORD);
        ahb_err("err_byte_delay", OFF_DELAY, 1'b1, 2'b00);
        ahb_rd(OFF_DELAY, rd); chk("delay_kept", rd, 32'h3);
        ahb_err("err_wr_status", OFF_STATUS, 1'b1, HSIZE_WORD);
        ahb_err("err_rd_ctrl", OFF_CTRL, 1'b0, HSIZE_WORD);
        chk("err_sleep_kept", sleep, 32'hF);

        // DELAY = 0: sleep on the edge after the finish edge
        ahb_wr(OFF_DELAY, 32'h0);
        ahb_wr(OFF_CTRL, 32'h1);
        pulse(0, t0);
        wait_rise(0);
        chk("rise0_d0", rise_cyc[0] - t0, 1);

        // Expiry and wake on the same edge: stays asleep
        ahb_wr(OFF_DELAY, 32'h2);
        ahb_wr(OFF_CTRL, 32'h2);
        chk("wake1", sleep, 32'hD);
        pulse(1, t0);
        ahb_wr(OFF_CTRL, 32'h2);
        chk("expire_vs_wake", rise_cyc[1] - t0, 3);
        repeat (3) @(negedge HCLK);
        chk("stay_asleep1", sleep, 32'hF);

        // DONE set and W1C on the same edge: set wins
        ahb_wr(OFF_CTRL, 32'h8);
        pulse(3, t0);
        ahb_wr(OFF_DONE, 32'h8);
        chk("rise3", rise_cyc[3] - t0, 3);
        ahb_rd(OFF_DONE, rd); chk("done_set_wins", rd, 32'hB);
        chk("irq_on", irq, 1);
        ahb_wr(OFF_DONE, 32'hF);
        ahb_rd(OFF_DONE, rd); chk("done_all_clr", rd, 0);

        // Reset in the middle of a write and a count
        ahb_wr(OFF_CTRL, 32'h1);
        pulse(0, t0);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = {24'h0, OFF_DELAY};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = 32'h55;
        #2 HRESETn = 1'b0;
        #1 chk("async_rst_sleep", sleep, 32'hF);
        @(negedge HCLK);
        HRESETn = 1'b1;
        ahb_rd(OFF_DELAY, rd);  chk("rst_abort_delay", rd, 32'h80);
        ahb_rd(OFF_STATUS, rd); chk("rst_abort_status", rd, 32'h0000_000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
